ct_had_pcfifo_ctrl: RTL and testbench
=====================================

// Module: ct_had_pcfifo_ctrl
// PURPOSE
//  HAD-side controller feeding the PC FIFO's ctrl_pcfifo_wen / ctrl_pcfifo_ren.
//  Gates recording of retired change-of-flow targets against debug mode and the
//  enable bit, and serves register-block read requests with a req/ack FSM.
//  Keeps a shadow occupancy count (0..DEPTH) plus a sticky overflow flag.
// PARAMETERS
//  DEPTH     16  PC FIFO entries; must match the FIFO instance
//  CNT_W     5   occupancy width, holds 0..DEPTH
//  DATAW     64  read data width
//  EXIT_DLY  2   cycles wen stays low after debug-mode exit (1..7)
// PORTS
//  cpuclk                  in   1      core clock
//  cpurst                  in   1      async reset, active-high
//  had_core_dbg_mode       in   1      core is in debug mode
//  regs_pcfifo_en          in   1      HCR PC-trace enable bit
//  regs_pcfifo_rd_req      in   1      read request; level, held until ack
//  regs_pcfifo_ovf_clr     in   1      pulse, clears overflow flag
//  rtu_had_xx_pcfifo_inst0_chgflow  in 1  retire slot 0 change-of-flow
//  rtu_had_xx_pcfifo_inst1_chgflow  in 1  retire slot 1 change-of-flow
//  rtu_had_xx_pcfifo_inst2_chgflow  in 1  retire slot 2 change-of-flow
//  pcfifo_regs_data        in   DATAW  FIFO read data (registered in FIFO)
//  ctrl_pcfifo_wen         out  1      FIFO write enable (FIFO flops it)
//  ctrl_pcfifo_ren         out  1      FIFO read pop, one-cycle pulse
//  pcfifo_rd_ack           out  1      read complete; high until req drops
//  pcfifo_rd_err           out  1      qualifies ack: read refused, data=0
//  pcfifo_rd_data          out  DATAW  captured read data
//  pcfifo_cnt              out  CNT_W  shadow occupancy
//  pcfifo_ovf              out  1      sticky: entries overwritten
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; exit counter 0; cnt 0.
//  wen (combinational from flops + inputs):
//  - wen = en & ~dbg_mode & (exit_cnt==0).
//  - Falling dbg_mode loads exit_cnt=EXIT_DLY; it decrements to 0.
//  - Rising dbg_mode clears exit_cnt to 0.
//  Push tracking:
//  - k_q <= wen ? popcount(chgflow[2:0]) : 0.
//  - k_q is applied one cycle later, aligned with the FIFO's flopped write.
//  Occupancy:
//  - sum = cnt + k_q - ren.
//  - cnt <= sum<0 ? 0 : sum>DEPTH ? DEPTH : sum.
//  - sum>DEPTH sets ovf; ovf_clr clears it. Set wins if both occur same cycle.
//  Read FSM:
//  - IDLE:
//    - req & ~(dbg_mode | ~en): -> ACK with rd_err=1, rd_data=0, no ren.
//    - req & wen==0 & k_q==0: -> REN.
//    - Otherwise stay in IDLE.
//  - REN: ren=1 for exactly this cycle -> CAPT.
//  - CAPT: FIFO output is now valid; rd_data <= pcfifo_regs_data,
//    rd_err <= 0 -> ACK.
//  - ACK: rd_ack=1 while req=1; req=0 -> IDLE, ack drops next cycle.
//  - Read latency: req to ack = 3 cycles on the normal path.
//  - Empty read (cnt==0): still pops. FIFO returns stale data; cnt stays 0.
//  - ren never coincides with a push (guarded by wen==0 & k_q==0), so the
//    FIFO never sees a simultaneous push and pop.
//  - req dropped in REN/CAPT: FSM completes to ACK, then returns to IDLE.
//    The pop is not undone.
//  Reset asserted mid-read: FSM returns to IDLE, ren=0, ack=0, rd_data=0.
// TESTING
//  - Reset release, en=1, dbg=0, chgflow=3'b111 for 1 cycle:
//    -> wen=1; cnt=3 two edges later; ovf=0.
//  - 6 cycles of 3'b111 from cnt=0:
//    -> cnt saturates at 16, ovf=1; ovf_clr pulse -> ovf=0, cnt stays 16.
//  - dbg=1, cnt=2, req=1:
//    -> ren pulse on cycle 1; ack on cycle 3 with rd_data=FIFO value;
//       cnt=1; drop req -> ack=0.
//  - Req in normal mode (en=1, dbg=0):
//    -> ack with rd_err=1, rd_data=0, no ren, cnt unchanged.
//  - dbg 1->0 with EXIT_DLY=2 and chgflow=3'b001 every cycle:
//    -> first 2 cycles ignored; third cycle wen=1 and counted.
//  - Reset asserted in CAPT:
//    -> FSM IDLE, all outputs 0; new req completes normally.

Source files
------------

// File: rtl/ct_had_pcfifo_ctrl_if.sv
// Register-block read handshake between the HAD register file and the PC FIFO controller.
// The register block is the master and holds the request level until the ack arrives.
interface ct_had_pcfifo_ctrl_if #(
    parameter int DATAW = 64
);
    logic             regs_pcfifo_rd_req;
    logic             pcfifo_rd_ack;
    logic             pcfifo_rd_err;
    logic [DATAW-1:0] pcfifo_rd_data;

    modport master (
        output regs_pcfifo_rd_req,
        input  pcfifo_rd_ack,
        input  pcfifo_rd_err,
        input  pcfifo_rd_data
    );

    modport slave (
        input  regs_pcfifo_rd_req,
        output pcfifo_rd_ack,
        output pcfifo_rd_err,
        output pcfifo_rd_data
    );
endinterface

// File: rtl/ct_had_pcfifo_ctrl.sv
// PC FIFO controller: gates change-of-flow recording, serves register reads, tracks occupancy.
// Read req->ack is 3 cycles (1 on a refused read); reads wait while a push is in flight.
module ct_had_pcfifo_ctrl #(
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 5,
    parameter int DATAW    = 64,
    parameter int EXIT_DLY = 2
) (
    input  logic                 cpuclk,
    input  logic                 cpurst,
    input  logic                 had_core_dbg_mode,
    input  logic                 regs_pcfifo_en,
    input  logic                 regs_pcfifo_ovf_clr,
    input  logic                 rtu_had_xx_pcfifo_inst0_chgflow,
    input  logic                 rtu_had_xx_pcfifo_inst1_chgflow,
    input  logic                 rtu_had_xx_pcfifo_inst2_chgflow,
    input  logic [DATAW-1:0]     pcfifo_regs_data,
    output logic                 ctrl_pcfifo_wen,
    output logic                 ctrl_pcfifo_ren,
    output logic [CNT_W-1:0]     pcfifo_cnt,
    output logic                 pcfifo_ovf,
    ct_had_pcfifo_ctrl_if.slave  rd_if
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REN  = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    localparam logic [2:0]             EXIT_LOAD = 3'(EXIT_DLY - 1);
    localparam logic signed [CNT_W+1:0] DEPTH_S  = (CNT_W+2)'(DEPTH);

    logic [1:0]         state_q, state_d;
    logic               dbg_q;
    logic [2:0]         exit_cnt_q, exit_cnt_d;
    logic [1:0]         k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               rd_err_q, rd_err_d;
    logic [DATAW-1:0]   rd_data_q, rd_data_d;
    logic signed [CNT_W+1:0] sum;
    logic               dbg_fall, dbg_rise;

    assign dbg_fall = dbg_q & ~had_core_dbg_mode;
    assign dbg_rise = ~dbg_q & had_core_dbg_mode;

    // The first cycle out of debug is blocked by dbg_q; the counter covers the remaining EXIT_DLY-1.
    assign ctrl_pcfifo_wen = regs_pcfifo_en & ~had_core_dbg_mode & ~dbg_q & (exit_cnt_q == 3'd0);
    assign ctrl_pcfifo_ren = (state_q == ST_REN);

    assign rd_if.pcfifo_rd_ack  = (state_q == ST_ACK);
    assign rd_if.pcfifo_rd_err  = rd_err_q;
    assign rd_if.pcfifo_rd_data = rd_data_q;
    assign pcfifo_cnt           = cnt_q;
    assign pcfifo_ovf           = ovf_q;

    always_comb begin
        exit_cnt_d = exit_cnt_q;
        if (dbg_rise) begin
            exit_cnt_d = 3'd0;
        end else if (dbg_fall) begin
            exit_cnt_d = EXIT_LOAD;
        end else if (exit_cnt_q != 3'd0) begin
            exit_cnt_d = exit_cnt_q - 3'd1;
        end
    end

    assign k_d = ctrl_pcfifo_wen ?
                 (2'({1'b0, rtu_had_xx_pcfifo_inst0_chgflow}) +
                  2'({1'b0, rtu_had_xx_pcfifo_inst1_chgflow}) +
                  2'({1'b0, rtu_had_xx_pcfifo_inst2_chgflow})) : 2'd0;

    // k_q lines up with the FIFO's own flopped write of the same entries.
    always_comb begin
        sum = $signed({2'b00, cnt_q})
            + $signed({{CNT_W{1'b0}}, k_q})
            - $signed({{(CNT_W+1){1'b0}}, ctrl_pcfifo_ren});
        if (sum[CNT_W+1]) begin
            cnt_d = '0;
        end else if (sum > DEPTH_S) begin
            cnt_d = CNT_W'(DEPTH);
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
        ovf_d = (sum > DEPTH_S) | (ovf_q & ~regs_pcfifo_ovf_clr);
    end

    always_comb begin
        state_d   = state_q;
        rd_err_d  = rd_err_q;
        rd_data_d = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_if.regs_pcfifo_rd_req) begin
                    if (regs_pcfifo_en & ~had_core_dbg_mode) begin
                        state_d   = ST_ACK;
                        rd_err_d  = 1'b1;
                        rd_data_d = '0;
                    end else if (~ctrl_pcfifo_wen && (k_q == 2'd0)) begin
                        state_d = ST_REN;
                    end
                end
            end
            ST_REN:  state_d = ST_CAPT;
            ST_CAPT: begin
                rd_data_d = pcfifo_regs_data;
                rd_err_d  = 1'b0;
                state_d   = ST_ACK;
            end
            ST_ACK: begin
                if (!rd_if.regs_pcfifo_rd_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q    <= ST_IDLE;
            dbg_q      <= 1'b0;
            exit_cnt_q <= 3'd0;
            k_q        <= 2'd0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            dbg_q      <= had_core_dbg_mode;
            exit_cnt_q <= exit_cnt_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_ct_had_pcfifo_ctrl.sv
// Bench for ct_had_pcfifo_ctrl: directed scenarios plus randomized traffic against a cycle reference model.
module tb_ct_had_pcfifo_ctrl;
    localparam int DEPTH    = 16;
    localparam int CNT_W    = 5;
    localparam int DATAW    = 64;
    localparam int EXIT_DLY = 2;

    logic             cpuclk = 1'b0;
    logic             cpurst;
    logic             dbg, en, clr;
    logic [2:0]       cf;
    logic [DATAW-1:0] fifo_out = '0;
    logic             wen, ren, ovf;
    logic [CNT_W-1:0] cnt;

    ct_had_pcfifo_ctrl_if #(.DATAW(DATAW)) rd_if ();

    ct_had_pcfifo_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DATAW(DATAW), .EXIT_DLY(EXIT_DLY)) dut (
        .cpuclk                          (cpuclk),
        .cpurst                          (cpurst),
        .had_core_dbg_mode               (dbg),
        .regs_pcfifo_en                  (en),
        .regs_pcfifo_ovf_clr             (clr),
        .rtu_had_xx_pcfifo_inst0_chgflow (cf[0]),
        .rtu_had_xx_pcfifo_inst1_chgflow (cf[1]),
        .rtu_had_xx_pcfifo_inst2_chgflow (cf[2]),
        .pcfifo_regs_data                (fifo_out),
        .ctrl_pcfifo_wen                 (wen),
        .ctrl_pcfifo_ren                 (ren),
        .pcfifo_cnt                      (cnt),
        .pcfifo_ovf                      (ovf),
        .rd_if                           (rd_if)
    );

    always #5 cpuclk = ~cpuclk;

    // FIFO stand-in: registered output presents a fresh word after every pop.
    always @(posedge cpuclk) if (ren) fifo_out <= {$urandom, $urandom};

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int               m_cnt, m_pend, m_since, m_rd;
    bit               m_ovf, m_err;
    logic [DATAW-1:0] m_data;
    // Expected outputs for the current cycle
    bit               e_wen, e_ren, e_ack, e_err, e_ovf;
    logic [CNT_W-1:0] e_cnt;
    logic [DATAW-1:0] e_data;
    // Inputs applied in the current cycle
    bit               i_en, i_dbg, i_clr, i_req;
    bit [2:0]         i_cf;

    task automatic model_reset();
        m_cnt = 0; m_pend = 0; m_since = 100; m_rd = 0;
        m_ovf = 0; m_err = 0; m_data = '0;
    endtask

    task automatic assert_reset();
        cpurst = 1'b1;
        en = 1'b0; dbg = 1'b0; cf = 3'b000; clr = 1'b0;
        rd_if.regs_pcfifo_rd_req = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        @(posedge cpuclk);
        @(negedge cpuclk);
        cpurst = 1'b0;
    endtask

    task automatic drive(input bit en_v, input bit dbg_v, input bit [2:0] cf_v, input bit clr_v, input bit req_v);
        @(negedge cpuclk);
        en = en_v; dbg = dbg_v; cf = cf_v; clr = clr_v;
        rd_if.regs_pcfifo_rd_req = req_v;
        i_en = en_v; i_dbg = dbg_v; i_cf = cf_v; i_clr = clr_v; i_req = req_v;
        #1;
        e_wen  = en_v && !dbg_v && (m_since >= EXIT_DLY);
        e_ren  = (m_rd == 1);
        e_ack  = (m_rd == 3);
        e_err  = m_err;
        e_data = m_data;
        e_cnt  = CNT_W'(m_cnt);
        e_ovf  = m_ovf;
    endtask

    // Apply the clock edge to the model: m_rd 0=idle, 1=pop cycle, 2=capture cycle, 3=acknowledging.
    task automatic advance();
        int sum;
        sum = m_cnt + m_pend - (e_ren ? 1 : 0);
        m_ovf = (sum > DEPTH) ? 1'b1 : (i_clr ? 1'b0 : m_ovf);
        m_cnt = (sum < 0) ? 0 : (sum > DEPTH) ? DEPTH : sum;
        case (m_rd)
            0: if (i_req) begin
                   if (i_en && !i_dbg) begin
                       m_rd = 3; m_err = 1'b1; m_data = '0;
                   end else if (!e_wen && m_pend == 0) begin
                       m_rd = 1;
                   end
               end
            1: m_rd = 2;
            2: begin m_data = fifo_out; m_err = 1'b0; m_rd = 3; end
            default: if (!i_req) m_rd = 0;
        endcase
        m_pend  = e_wen ? $countones(i_cf) : 0;
        m_since = i_dbg ? 0 : ((m_since < 100) ? m_since + 1 : 100);
        @(posedge cpuclk);
    endtask

    task automatic test_reset();
        assert_reset();
        #1;
        vectors++; if (wen !== 1'b0) begin miscompares++; $display("FAIL reset_wen got=%b exp=0", wen); end
        vectors++; if (ren !== 1'b0) begin miscompares++; $display("FAIL reset_ren got=%b exp=0", ren); end
        vectors++; if (rd_if.pcfifo_rd_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got=%b exp=0", rd_if.pcfifo_rd_ack); end
        vectors++; if (rd_if.pcfifo_rd_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", rd_if.pcfifo_rd_err); end
        vectors++; if (rd_if.pcfifo_rd_data !== 64'd0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", rd_if.pcfifo_rd_data); end
        vectors++; if (cnt !== 5'd0) begin miscompares++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        release_reset();
    endtask

    task automatic test_push_basic();
        drive(1, 0, 3'b111, 0, 0);
        vectors++; if (wen !== 1'b1) begin miscompares++; $display("FAIL push_wen got=%b exp=1", wen); end
        advance();
        drive(1, 0, 3'b000, 0, 0);
        vectors++; if (cnt !== 5'd0) begin miscompares++; $display("FAIL push_cnt_early got=%0d exp=0", cnt); end
        advance();
        drive(1, 0, 3'b000, 0, 0);
        vectors++; if (cnt !== 5'd3) begin miscompares++; $display("FAIL push_cnt got=%0d exp=3", cnt); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL push_ovf got=%b exp=0", ovf); end
        advance();
    endtask

    task automatic test_saturation();
        assert_reset();
        release_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 3'b111, 0, 0);
            vectors++; if (cnt !== e_cnt) begin miscompares++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, cnt, e_cnt); end
            advance();
        end
        drive(1, 0, 3'b000, 0, 0); advance();
        drive(1, 0, 3'b000, 0, 0);
        vectors++; if (cnt !== 5'd16) begin miscompares++; $display("FAIL sat_cnt_full got=%0d exp=16", cnt); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL sat_ovf got=%b exp=1", ovf); end
        advance();
        drive(1, 0, 3'b000, 1, 0); advance();
        drive(1, 0, 3'b000, 0, 0);
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL sat_ovf_clr got=%b exp=0", ovf); end
        vectors++; if (cnt !== 5'd16) begin miscompares++; $display("FAIL sat_cnt_hold got=%0d exp=16", cnt); end
        advance();
    endtask

    task automatic test_debug_read();
        assert_reset();
        release_reset();
        drive(1, 0, 3'b011, 0, 0); advance();
        drive(1, 1, 3'b000, 0, 0); advance();
        drive(1, 1, 3'b000, 0, 1);
        vectors++; if (cnt !== 5'd2) begin miscompares++; $display("FAIL dread_cnt0 got=%0d exp=2", cnt); end
        advance();
        drive(1, 1, 3'b000, 0, 1);
        vectors++; if (ren !== 1'b1) begin miscompares++; $display("FAIL dread_ren got=%b exp=1", ren); end
        advance();
        drive(1, 1, 3'b000, 0, 1);
        vectors++; if (ren !== 1'b0 || rd_if.pcfifo_rd_ack !== 1'b0) begin miscompares++; $display("FAIL dread_capt ren=%b ack=%b exp=0,0", ren, rd_if.pcfifo_rd_ack); end
        advance();
        drive(1, 1, 3'b000, 0, 1);
        vectors++; if (rd_if.pcfifo_rd_ack !== 1'b1) begin miscompares++; $display("FAIL dread_ack got=%b exp=1", rd_if.pcfifo_rd_ack); end
        vectors++; if (rd_if.pcfifo_rd_data !== e_data) begin miscompares++; $display("FAIL dread_data got=%h exp=%h", rd_if.pcfifo_rd_data, e_data); end
        vectors++; if (rd_if.pcfifo_rd_err !== 1'b0) begin miscompares++; $display("FAIL dread_err got=%b exp=0", rd_if.pcfifo_rd_err); end
        vectors++; if (cnt !== 5'd1) begin miscompares++; $display("FAIL dread_cnt got=%0d exp=1", cnt); end
        advance();
        drive(1, 1, 3'b000, 0, 0);
        vectors++; if (rd_if.pcfifo_rd_ack !== 1'b1) begin miscompares++; $display("FAIL dread_ack_hold got=%b exp=1", rd_if.pcfifo_rd_ack); end
        advance();
        drive(1, 1, 3'b000, 0, 0);
        vectors++; if (rd_if.pcfifo_rd_ack !== 1'b0) begin miscompares++; $display("FAIL dread_ack_drop got=%b exp=0", rd_if.pcfifo_rd_ack); end
        advance();
    endtask

    task automatic test_err_read();
        drive(1, 0, 3'b000, 0, 1);
        vectors++; if (ren !== 1'b0) begin miscompares++; $display("FAIL eread_ren0 got=%b exp=0", ren); end
        advance();
        drive(1, 0, 3'b000, 0, 1);
        vectors++; if (rd_if.pcfifo_rd_ack !== 1'b1) begin miscompares++; $display("FAIL eread_ack got=%b exp=1", rd_if.pcfifo_rd_ack); end
        vectors++; if (rd_if.pcfifo_rd_err !== 1'b1) begin miscompares++; $display("FAIL eread_err got=%b exp=1", rd_if.pcfifo_rd_err); end
        vectors++; if (rd_if.pcfifo_rd_data !== 64'd0) begin miscompares++; $display("FAIL eread_data got=%h exp=0", rd_if.pcfifo_rd_data); end
        vectors++; if (ren !== 1'b0) begin miscompares++; $display("FAIL eread_ren1 got=%b exp=0", ren); end
        vectors++; if (cnt !== 5'd1) begin miscompares++; $display("FAIL eread_cnt got=%0d exp=1", cnt); end
        advance();
        drive(1, 0, 3'b000, 0, 0); advance();
        drive(1, 0, 3'b000, 0, 0);
        vectors++; if (rd_if.pcfifo_rd_ack !== 1'b0) begin miscompares++; $display("FAIL eread_ack_drop got=%b exp=0", rd_if.pcfifo_rd_ack); end
        advance();
    endtask

    task automatic test_exit_delay();
        assert_reset();
        release_reset();
        drive(1, 1, 3'b001, 0, 0); advance();
        drive(1, 1, 3'b001, 0, 0); advance();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 3'b001, 0, 0);
            vectors++; if (wen !== (i >= EXIT_DLY)) begin miscompares++; $display("FAIL exit_wen i=%0d got=%b exp=%b", i, wen, (i >= EXIT_DLY)); end
            advance();
        end
        drive(0, 0, 3'b000, 0, 0); advance();
        drive(0, 0, 3'b000, 0, 0);
        vectors++; if (cnt !== 5'd3) begin miscompares++; $display("FAIL exit_cnt got=%0d exp=3", cnt); end
        advance();
    endtask

    task automatic test_reset_mid_read();
        assert_reset();
        release_reset();
        drive(1, 0, 3'b001, 0, 0); advance();
        drive(0, 1, 3'b000, 0, 0); advance();
        drive(0, 1, 3'b000, 0, 1); advance();
        drive(0, 1, 3'b000, 0, 1);
        vectors++; if (ren !== 1'b1) begin miscompares++; $display("FAIL mrst_ren got=%b exp=1", ren); end
        advance();
        drive(0, 1, 3'b000, 0, 1);
        assert_reset();
        #1;
        vectors++; if (ren !== 1'b0 || rd_if.pcfifo_rd_ack !== 1'b0) begin miscompares++; $display("FAIL mrst_ctl ren=%b ack=%b exp=0,0", ren, rd_if.pcfifo_rd_ack); end
        vectors++; if (rd_if.pcfifo_rd_data !== 64'd0 || rd_if.pcfifo_rd_err !== 1'b0) begin miscompares++; $display("FAIL mrst_data data=%h err=%b exp=0,0", rd_if.pcfifo_rd_data, rd_if.pcfifo_rd_err); end
        vectors++; if (cnt !== 5'd0 || ovf !== 1'b0) begin miscompares++; $display("FAIL mrst_cnt cnt=%0d ovf=%b exp=0,0", cnt, ovf); end
        release_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 3'b000, 0, 1);
            vectors++; if (ren !== (i == 1)) begin miscompares++; $display("FAIL mrst_ren2 i=%0d got=%b exp=%b", i, ren, (i == 1)); end
            advance();
        end
        drive(0, 1, 3'b000, 0, 1);
        vectors++; if (rd_if.pcfifo_rd_ack !== 1'b1) begin miscompares++; $display("FAIL mrst_ack got=%b exp=1", rd_if.pcfifo_rd_ack); end
        vectors++; if (rd_if.pcfifo_rd_data !== e_data) begin miscompares++; $display("FAIL mrst_data2 got=%h exp=%h", rd_if.pcfifo_rd_data, e_data); end
        vectors++; if (cnt !== 5'd0) begin miscompares++; $display("FAIL mrst_empty_cnt got=%0d exp=0", cnt); end
        advance();
        drive(0, 1, 3'b000, 0, 0); advance();
    endtask

    task automatic test_random();
        bit r_en, r_dbg, r_req, r_clr;
        bit [2:0] r_cf;
        assert_reset();
        release_reset();
        r_en = 1'b1; r_dbg = 1'b0; r_req = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0) r_en = ~r_en;
            if ($urandom_range(0, 9) == 0) r_dbg = ~r_dbg;
            if (!r_req) r_req = ($urandom_range(0, 3) == 0);
            else if (m_rd == 3) r_req = ($urandom_range(0, 1) == 0);
            else if ($urandom_range(0, 15) == 0) r_req = 1'b0;
            r_cf  = 3'($urandom);
            r_clr = ($urandom_range(0, 7) == 0);
            drive(r_en, r_dbg, r_cf, r_clr, r_req);
            vectors++; if (wen !== e_wen) begin miscompares++; $display("FAIL rnd_wen c=%0d got=%b exp=%b", c, wen, e_wen); end
            vectors++; if (ren !== e_ren) begin miscompares++; $display("FAIL rnd_ren c=%0d got=%b exp=%b", c, ren, e_ren); end
            vectors++; if (rd_if.pcfifo_rd_ack !== e_ack) begin miscompares++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, rd_if.pcfifo_rd_ack, e_ack); end
            vectors++; if (rd_if.pcfifo_rd_err !== e_err) begin miscompares++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, rd_if.pcfifo_rd_err, e_err); end
            vectors++; if (rd_if.pcfifo_rd_data !== e_data) begin miscompares++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, rd_if.pcfifo_rd_data, e_data); end
            vectors++; if (cnt !== e_cnt) begin miscompares++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, cnt, e_cnt); end
            vectors++; if (ovf !== e_ovf) begin miscompares++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, ovf, e_ovf); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_push_basic();
        test_saturation();
        test_debug_read();
        test_err_read();
        test_exit_delay();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
